spi_slave_regmap_param: RTL

Parametrised SPI slave with a register map, and the successor of the fixed 8-bit Mode-0 GPIO slave. It supports all four SPI modes, configurable address and data widths, a configurable register count, a sticky error/status register and optional burst auto-increment. All logic runs on the system clock, and the SPI pins are oversampled. It sits between an external SPI master and on-chip GPIO/control registers.

---
 rtl/spi_slave_regmap_param.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/spi_slave_regmap_param.sv
// Oversampled SPI slave (any CPOL/CPHA) in front of a small register map on clk.
// Optional feature: define SPI_REGMAP_BURST_EN to auto-increment the address per data word.
//
// state   | meaning
// ARMWAIT | after reset, wait for cs high so a frame already in flight is ignored
// IDLE    | no frame, waiting for cs low
// CMD     | receiving command byte (bit0 = write)
// ADDR    | receiving address
// DATA    | receiving / transmitting data words
module spi_slave_regmap_param #(
  parameter int                DATA_W   = 8,
  parameter int                ADDR_W   = 8,
  parameter int                NUM_REGS = 16,
  parameter int                CPOL     = 0,
  parameter int                CPHA     = 0,
  parameter int                GPIO_W   = 8,
  parameter logic [DATA_W-1:0] ID_VALUE = 'hA5,
  parameter logic [GPIO_W-1:0] GPIO_RST = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cs,
  input  logic              sclk,
  input  logic              mosi,
  output logic              miso,
  input  logic [GPIO_W-1:0] gpio_in,
  output logic [GPIO_W-1:0] gpio_out
);

  localparam int   SH_W  = (DATA_W > ADDR_W) ? DATA_W : ADDR_W;
  localparam int   IDX_W = $clog2(NUM_REGS);
  localparam logic POL   = (CPOL != 0);
  localparam logic PHA   = (CPHA != 0);
  localparam logic [ADDR_W-1:0] A_ID    = ADDR_W'(0);
  localparam logic [ADDR_W-1:0] A_GPIN  = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] A_GPOUT = ADDR_W'(2);
  localparam logic [ADDR_W-1:0] A_STAT  = ADDR_W'(3);
  localparam logic [ADDR_W-1:0] A_SCR   = ADDR_W'(4);

  typedef enum logic [2:0] {ARMWAIT, IDLE, CMD, ADDR, DATA} state_t;

  state_t              state, state_nxt;
  logic [1:0]          arm_tmr;
  logic [1:0]          cs_q, mosi_q;
  logic [2:0]          sclk_q;
  logic [GPIO_W-1:0]   gpio_q1, gpio_q2;
  logic                cs_s, mosi_s, sclk_n2, sclk_n3, sample_ev, shift_ev;
  logic                frame_active, field_done, word_done;
  logic [5:0]          bit_cnt, field_last;
  logic [SH_W-1:0]     rx_sh, rx_next;
  logic [DATA_W-1:0]   tx_sh, rx_word;
  logic [ADDR_W-1:0]   addr, rx_addr;
  logic                rw, extra, abort, oor;
  logic                wr_en, set_abort, set_oor, clr_abort, clr_oor;
  logic [DATA_W-1:0]   regs [NUM_REGS];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cs_q    <= 2'b11;
      sclk_q  <= {3{POL}};
      mosi_q  <= '0;
      gpio_q1 <= '0;
      gpio_q2 <= '0;
    end else begin
      cs_q    <= {cs_q[0], cs};
      sclk_q  <= {sclk_q[1:0], sclk};
      mosi_q  <= {mosi_q[0], mosi};
      gpio_q1 <= gpio_in;
      gpio_q2 <= gpio_q1;
    end
  end

  // sclk normalised so idle is 0: leading edge rises, trailing edge falls
  assign cs_s      = cs_q[1];
  assign mosi_s    = mosi_q[1];
  assign sclk_n2   = sclk_q[1] ^ POL;
  assign sclk_n3   = sclk_q[2] ^ POL;
  assign sample_ev = PHA ? (~sclk_n2 & sclk_n3) : (sclk_n2 & ~sclk_n3);
  assign shift_ev  = PHA ? (sclk_n2 & ~sclk_n3) : (~sclk_n2 & sclk_n3);

  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return 32'(a) < 32'(NUM_REGS);
  endfunction

  function automatic logic [DATA_W-1:0] rd_data(input logic [ADDR_W-1:0] a);
    logic [DATA_W-1:0] d;
    d = '0;
    if (a == A_ID)        d = ID_VALUE;
    else if (a == A_GPIN) d = DATA_W'(gpio_q2);
    else if (a == A_STAT) d[1:0] = {oor, abort};
    else if (in_range(a)) d = regs[a[IDX_W-1:0]];
    return d;
  endfunction

  // arm_tmr covers the synchroniser flush so the reset value of cs_q cannot fake an idle bus
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= ARMWAIT;
      arm_tmr <= 2'd2;
    end else begin
      state <= state_nxt;
      if (arm_tmr != 2'd0) arm_tmr <= arm_tmr - 2'd1;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ARMWAIT: if (arm_tmr == 2'd0 && cs_s) state_nxt = IDLE;
      IDLE:    if (!cs_s) state_nxt = CMD;
      CMD:     if (cs_s) state_nxt = IDLE; else if (field_done) state_nxt = ADDR;
      ADDR:    if (cs_s) state_nxt = IDLE; else if (field_done) state_nxt = DATA;
      DATA:    if (cs_s) state_nxt = IDLE;
      default: state_nxt = ARMWAIT;
    endcase
  end

  always_comb begin
    field_last = 6'd7;
    case (state)
      ADDR:    field_last = 6'(ADDR_W - 1);
      DATA:    field_last = 6'(DATA_W - 1);
      default: ;
    endcase
  end

  assign frame_active = (state == CMD) || (state == ADDR) || (state == DATA);
  assign field_done   = frame_active && !cs_s && sample_ev && (bit_cnt == field_last);
  assign word_done    = field_done && (state == DATA) && !extra;
  assign rx_next      = {rx_sh[SH_W-2:0], mosi_s};
  assign rx_word      = rx_next[DATA_W-1:0];
  assign rx_addr      = rx_next[ADDR_W-1:0];

  assign wr_en     = word_done && rw && in_range(addr) && (addr == A_GPOUT || addr >= A_SCR);
  assign set_oor   = word_done && !in_range(addr);
  assign clr_oor   = word_done && rw && (addr == A_STAT) && rx_word[1];
  assign clr_abort = word_done && rw && (addr == A_STAT) && rx_word[0];
  assign set_abort = frame_active && cs_s && (bit_cnt != 6'd0) && !extra;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bit_cnt <= '0;
      rx_sh   <= '0;
      tx_sh   <= '0;
      addr    <= '0;
      rw      <= 1'b0;
      extra   <= 1'b0;
      miso    <= 1'b0;
      abort   <= 1'b0;
      oor     <= 1'b0;
      regs    <= '{default: '0};
      regs[2] <= DATA_W'(GPIO_RST);
    end else begin
      abort <= (abort & ~clr_abort) | set_abort;
      oor   <= (oor & ~clr_oor) | set_oor;
      if (wr_en) regs[addr[IDX_W-1:0]] <= rx_word;
      if (!frame_active || cs_s) begin
        bit_cnt <= '0;
        tx_sh   <= '0;
        extra   <= 1'b0;
        miso    <= 1'b0;
      end else if (sample_ev) begin
        rx_sh   <= rx_next;
        bit_cnt <= field_done ? 6'd0 : bit_cnt + 6'd1;
        if (field_done && state == CMD) rw <= rx_next[0];
        if (field_done && state == ADDR) begin
          addr  <= rx_addr;
          tx_sh <= rd_data(rx_addr);
        end
        if (field_done && state == DATA) begin
`ifdef SPI_REGMAP_BURST_EN
          addr  <= addr + ADDR_W'(1);
          tx_sh <= rd_data(addr + ADDR_W'(1));
`else
          extra <= 1'b1;
          tx_sh <= '0;
`endif
        end
      end else if (shift_ev) begin
        if (state == DATA && !extra) begin
          miso  <= tx_sh[DATA_W-1];
          tx_sh <= {tx_sh[DATA_W-2:0], 1'b0};
        end else begin
          miso <= 1'b0;
        end
      end
    end
  end

  assign gpio_out = regs[2][GPIO_W-1:0];

endmodule
